// File: rtl/g11620_scan_sched.sv
// -----------------------------------------------------------------------------
// g11620_scan_sched
//
// Scan scheduler and configuration-register owner for one G11620 line-sensor
// driver. Holds the 16x32 configuration register file, serves the driver's
// one-cycle-latency read port, arbitrates host access to the file, issues
// start pulses at the programmed period for the programmed number of scans,
// and aborts runs through the driver's soft reset.
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   host_wr/host_rd       host write / read strobes (single cycle)
//   host_addr/host_wdata  host register address / write data
//   host_rdata/host_rvalid host read data, valid for one cycle
//   drv_start_o           one-cycle start pulse to the driver
//   drv_soft_reset_o      abort request to the driver (two cycles)
//   drv_done_i            driver done level (rising edge counts a scan)
//   drv_ram_rd_i/addr_i   driver register read strobe / address ([7:4] unused)
//   drv_ram_dout_o        driver read data, registered, held between reads
//   busy_o                run in progress
//   frame_cnt_o           completed scans in the current or last run
//   irq_o                 one-cycle pulse at every run end
//
// Register map: 0 CTRL (GO, CONT, ABORT), 1 INTEG, 2 CAP, 3 PERIOD,
// 4 NFRAMES, 5 TIMEOUT, 6 STATUS (read-only), 7-15 general purpose.
//
// Build option: define G11620_SCHED_TIMEOUT_EN to add a 32-bit WAIT_DONE
// watchdog loaded from TIMEOUT at each START (TIMEOUT=0 disables it).
// Without it, register 5 is plain storage and STATUS bit1 reads 0.
// -----------------------------------------------------------------------------
module g11620_scan_sched #(
    parameter int NFRAME_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                host_wr,
    input  logic                host_rd,
    input  logic [3:0]          host_addr,
    input  logic [31:0]         host_wdata,
    output logic [31:0]         host_rdata,
    output logic                host_rvalid,
    output logic                drv_start_o,
    output logic                drv_soft_reset_o,
    input  logic                drv_done_i,
    input  logic                drv_ram_rd_i,
    input  logic [7:0]          drv_ram_addr_i,
    output logic [31:0]         drv_ram_dout_o,
    output logic                busy_o,
    output logic [NFRAME_W-1:0] frame_cnt_o,
    output logic                irq_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP,
        S_ABORT
    } state_t;

    localparam logic [NFRAME_W:0] ONE_EXT = 1;

    logic [31:0]         regs [16];
    logic                wr_err;
    logic                aborted;
    logic                timeout_flag;
    state_t              state;
    logic                done_q;
    logic [31:0]         gap_cnt;
    logic                ab_cnt;
    logic                rd_pend;
    logic [3:0]          pend_addr;
`ifdef G11620_SCHED_TIMEOUT_EN
    logic [31:0]         wd_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    logic                ctrl_wr, go_wr, abort_wr, done_rise, last_scan, cont;
    logic [31:0]         period, status;
    logic [NFRAME_W-1:0] nframes, fc_inc;
    logic [NFRAME_W:0]   fc_plus1;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^drv_ram_addr_i[7:4];

    assign ctrl_wr   = host_wr && (host_addr == 4'd0);
    assign go_wr     = ctrl_wr && host_wdata[0];
    assign abort_wr  = ctrl_wr && host_wdata[2];
    assign cont      = regs[0][1];
    assign period    = regs[3];
    assign nframes   = regs[4][NFRAME_W-1:0];
    assign done_rise = drv_done_i && !done_q;

    // Saturating increment: the carry out of the extended sum means the
    // counter is already all-ones.
    assign fc_plus1  = {1'b0, frame_cnt_o} + ONE_EXT;
    assign fc_inc    = fc_plus1[NFRAME_W] ? frame_cnt_o : fc_plus1[NFRAME_W-1:0];
    // NFRAMES=0 is treated as a single-scan run.
    assign last_scan = !cont && ((nframes == '0) || (fc_plus1 == {1'b0, nframes}));

    assign status = {16'(frame_cnt_o), 12'd0, wr_err, aborted, timeout_flag, busy_o};

    function automatic logic [31:0] rd_mux(input logic [3:0] a);
        return (a == 4'd6) ? status : regs[a];
    endfunction

    // -------------------------------------------------------------------------
    // Register file and host write path
    // -------------------------------------------------------------------------
    // NOTE: the file is only 16 words and its reset value is architectural
    // (all registers read 0 after reset), so every word is reset here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            wr_err <= 1'b0;
        end else begin
            if (host_wr) begin
                if (host_addr == 4'd0) begin
                    // GO and ABORT are strobes; only CONT and spare bits persist.
                    regs[0] <= host_wdata & ~32'h0000_0005;
                end else if (host_addr != 4'd6) begin
                    if (busy_o && (host_addr <= 4'd5)) wr_err <= 1'b1;
                    else                               regs[host_addr] <= host_wdata;
                end
            end
            if (go_wr) wr_err <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: the driver read always wins; a colliding host read is parked
    // for one cycle and served next.
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every block
    // sees the pre-edge values of the others regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drv_ram_dout_o <= '0;
            host_rdata     <= '0;
            host_rvalid    <= 1'b0;
            rd_pend        <= 1'b0;
            pend_addr      <= '0;
        end else begin
            if (drv_ram_rd_i) drv_ram_dout_o <= rd_mux(drv_ram_addr_i[3:0]);
            host_rvalid <= 1'b0;
            if (rd_pend) begin
                host_rvalid <= 1'b1;
                host_rdata  <= rd_mux(pend_addr);
            end else if (host_rd && !drv_ram_rd_i) begin
                host_rvalid <= 1'b1;
                host_rdata  <= rd_mux(host_addr);
            end
            rd_pend <= host_rd && (drv_ram_rd_i || rd_pend);
            if (host_rd) pend_addr <= host_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Scan FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            busy_o           <= 1'b0;
            drv_start_o      <= 1'b0;
            drv_soft_reset_o <= 1'b0;
            irq_o            <= 1'b0;
            frame_cnt_o      <= '0;
            aborted          <= 1'b0;
            done_q           <= 1'b0;
            gap_cnt          <= '0;
            ab_cnt           <= 1'b0;
`ifdef G11620_SCHED_TIMEOUT_EN
            timeout_flag     <= 1'b0;
            wd_cnt           <= '0;
`endif
        end else begin
            done_q      <= drv_done_i;
            drv_start_o <= 1'b0;
            irq_o       <= 1'b0;
            if (go_wr) begin
                aborted <= 1'b0;
`ifdef G11620_SCHED_TIMEOUT_EN
                timeout_flag <= 1'b0;
`endif
            end

            if (abort_wr && (state != S_IDLE) && (state != S_ABORT)) begin
                state            <= S_ABORT;
                drv_soft_reset_o <= 1'b1;
                ab_cnt           <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go_wr && !host_wdata[2]) begin
                            frame_cnt_o <= '0;
                            busy_o      <= 1'b1;
                            state       <= S_START;
                        end
                    end
                    S_START: begin
                        drv_start_o <= 1'b1;
                        state       <= S_WAIT_DONE;
`ifdef G11620_SCHED_TIMEOUT_EN
                        wd_cnt      <= regs[5];
`endif
                    end
                    S_WAIT_DONE: begin
                        if (done_rise) begin
                            frame_cnt_o <= fc_inc;
                            if (last_scan) begin
                                busy_o <= 1'b0;
                                irq_o  <= 1'b1;
                                state  <= S_IDLE;
                            end else if (period == '0) begin
                                state <= S_START;
                            end else begin
                                // GAP holds PERIOD cycles; START then adds one,
                                // placing the next pulse PERIOD+2 after done.
                                gap_cnt <= period - 32'd1;
                                state   <= S_GAP;
                            end
                        end
`ifdef G11620_SCHED_TIMEOUT_EN
                        else if (wd_cnt == 32'd1) begin
                            timeout_flag     <= 1'b1;
                            drv_soft_reset_o <= 1'b1;
                            ab_cnt           <= 1'b0;
                            state            <= S_ABORT;
                        end else if (wd_cnt != '0) begin
                            wd_cnt <= wd_cnt - 32'd1;
                        end
`endif
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) state <= S_START;
                        else               gap_cnt <= gap_cnt - 32'd1;
                    end
                    S_ABORT: begin
                        if (!ab_cnt) begin
                            ab_cnt <= 1'b1;
                        end else begin
                            drv_soft_reset_o <= 1'b0;
                            aborted          <= 1'b1;
                            busy_o           <= 1'b0;
                            irq_o            <= 1'b1;
                            state            <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_g11620_scan_sched.sv
// -----------------------------------------------------------------------------
// Testbench for g11620_scan_sched: register file/read ports, arbitration,
// scan scheduling, write protection, abort, watchdog and mid-run reset,
// checked against a behavioural model of the register map and run timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_g11620_scan_sched;
    localparam int NFW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           host_wr = 1'b0, host_rd = 1'b0;
    logic [3:0]     host_addr = '0;
    logic [31:0]    host_wdata = '0;
    logic [31:0]    host_rdata;
    logic           host_rvalid;
    logic           drv_start_o, drv_soft_reset_o;
    logic           drv_done_i = 1'b0;
    logic           drv_ram_rd_i = 1'b0;
    logic [7:0]     drv_ram_addr_i = '0;
    logic [31:0]    drv_ram_dout_o;
    logic           busy_o;
    logic [NFW-1:0] frame_cnt_o;
    logic           irq_o;

    g11620_scan_sched #(.NFRAME_W(NFW)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .drv_start_o(drv_start_o), .drv_soft_reset_o(drv_soft_reset_o),
        .drv_done_i(drv_done_i), .drv_ram_rd_i(drv_ram_rd_i),
        .drv_ram_addr_i(drv_ram_addr_i), .drv_ram_dout_o(drv_ram_dout_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard counters and check ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- output monitors (sampled on the falling edge) ----------------
    int start_q[$];
    int done_q[$];
    int irq_n = 0, irq_cyc = 0, soft_n = 0, soft_first = -1;

    always @(negedge clk) begin
        if (drv_start_o) start_q.push_back(cyc);
        if (irq_o) begin irq_n++; irq_cyc = cyc; end
        if (drv_soft_reset_o) begin
            if (soft_n == 0) soft_first = cyc;
            soft_n++;
        end
    end

    task automatic clear_mon();
        start_q.delete(); done_q.delete();
        irq_n = 0; soft_n = 0; soft_first = -1;
    endtask

    // ---------------- sensor driver model: done resp_dly cycles after start ----------------
    bit resp_en = 1'b0;
    int resp_dly = 50;

    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && drv_start_o) begin
                repeat (resp_dly) @(posedge clk);
                #1 drv_done_i = 1'b1;
                done_q.push_back(cyc);
                repeat (2) @(posedge clk);
                #1 drv_done_i = 1'b0;
            end
        end
    end

    // ---------------- behavioural register-map model ----------------
    logic [31:0] m_regs [16];
    logic        m_wr_err, m_aborted, m_timeout, m_busy;
    logic [15:0] m_fc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_wr_err = 0; m_aborted = 0; m_timeout = 0; m_busy = 0; m_fc = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'd6) return {m_fc, 12'd0, m_wr_err, m_aborted, m_timeout, m_busy};
        return m_regs[a];
    endfunction

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        host_wr = 1'b1; host_addr = a; host_wdata = d;
        if (a == 4'd0) begin
            m_regs[0] = d & ~32'h5;
            if (d[0]) begin m_wr_err = 0; m_aborted = 0; m_timeout = 0; end
        end else if (a != 4'd6) begin
            if (m_busy && a <= 4'd5) m_wr_err = 1;
            else                     m_regs[a] = d;
        end
        tick();
        host_wr = 1'b0;
    endtask

    task automatic drv_read(input string tag, input logic [3:0] a);
        logic [31:0] e;
        e = m_read(a);
        drv_ram_rd_i = 1'b1; drv_ram_addr_i = {4'($urandom), a};
        tick();
        drv_ram_rd_i = 1'b0;
        check(tag, drv_ram_dout_o, e);
    endtask

    task automatic host_read(input string tag, input logic [3:0] a);
        logic [31:0] e;
        e = m_read(a);
        host_rd = 1'b1; host_addr = a;
        tick();
        host_rd = 1'b0;
        check({tag, "_rvalid"}, 32'(host_rvalid), 1);
        check(tag, host_rdata, e);
    endtask

    task automatic wait_irq(input string tag, input int limit);
        int k;
        k = 0;
        while (irq_n == 0 && k < limit) begin tick(); k++; end
        check({tag, "_irq_seen"}, 32'(irq_n != 0), 1);
    endtask

    // Counted run: expected start times follow from the GO cycle, the recorded
    // done edges and PERIOD; scan count from NFRAMES (0 means one scan).
    task automatic run_check(input string tag, input int nfr, input int per, input int dly,
                             input bit prot);
        int scans, go_c, n;
        host_write(4, nfr);
        host_write(3, per);
        resp_dly = dly; resp_en = 1'b1;
        clear_mon();
        go_c = cyc;
        host_write(0, 32'h1);
        m_busy = 1; m_fc = '0;
        scans = (nfr == 0) ? 1 : nfr;
        if (prot) begin
            repeat (5) tick();
            host_write(1, 32'd7);
            host_write(9, $urandom);
        end
        wait_irq(tag, 3000);
        repeat (4) tick();
        m_busy = 0; m_fc = 16'(scans);
        check({tag, "_irq_count"},  irq_n, 1);
        check({tag, "_start_count"}, start_q.size(), scans);
        check({tag, "_frame_cnt"},  32'(frame_cnt_o), scans);
        check({tag, "_busy"},       32'(busy_o), 0);
        if (start_q.size() > 0) check({tag, "_first_start"}, start_q[0], go_c + 2);
        n = (start_q.size() < done_q.size() + 1) ? start_q.size() : done_q.size() + 1;
        for (int i = 1; i < n; i++)
            check($sformatf("%s_start%0d", tag, i), start_q[i], done_q[i-1] + per + 2);
        if (done_q.size() > 0) check({tag, "_irq_time"}, irq_cyc, done_q[done_q.size()-1] + 1);
    endtask

    // ---------------- global time bound ----------------
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time bound exceeded");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k, ab_c, go_c;
        logic [31:0] v;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy",  32'(busy_o), 0);
        check("rst_start", 32'(drv_start_o), 0);
        check("rst_soft",  32'(drv_soft_reset_o), 0);
        check("rst_irq",   32'(irq_o), 0);
        check("rst_fc",    32'(frame_cnt_o), 0);
        check("rst_rvalid", 32'(host_rvalid), 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_dout",  drv_ram_dout_o, 0);
        rst_n = 1'b1;
        tick();

        // Register file: directed INTEG/CAP and random contents elsewhere
        host_write(1, 32'd100);
        host_write(2, 32'd3);
        for (int a = 3; a < 16; a++) host_write(4'(a), $urandom);
        host_write(5, 32'd0);
        drv_read("drv_integ", 4'd1);
        tick();
        check("drv_integ_held", drv_ram_dout_o, 32'd100);
        drv_read("drv_cap", 4'd2);
        v = $urandom;
        host_write(9, v);
        drv_read("drv_wr_then_rd", 4'd9);
        for (int a = 0; a < 16; a++) host_read($sformatf("hr%0d", a), 4'(a));
        for (int i = 0; i < 4; i++) begin
            k = $urandom_range(0, 15);
            drv_read($sformatf("drv_rand%0d", i), 4'(k));
        end

        // Host/driver read collision on INTEG
        v = m_read(4'd1);
        host_rd = 1'b1; drv_ram_rd_i = 1'b1; host_addr = 4'd1; drv_ram_addr_i = 8'h01;
        tick();
        host_rd = 1'b0; drv_ram_rd_i = 1'b0;
        check("col_drv_data", drv_ram_dout_o, v);
        check("col_rvalid_n1", 32'(host_rvalid), 0);
        tick();
        check("col_rvalid_n2", 32'(host_rvalid), 1);
        check("col_host_data", host_rdata, v);

        // Scheduled runs: directed, then randomized
        run_check("run3", 3, 10, 50, 1'b0);
        for (int r = 0; r < 3; r++)
            run_check($sformatf("rrun%0d", r), $urandom_range(0, 4), $urandom_range(0, 6),
                      $urandom_range(3, 12), 1'b0);

        // Continuous run aborted after 5 scans
        host_write(3, 10);
        resp_dly = 50; resp_en = 1'b1;
        clear_mon();
        host_write(0, 32'h3);
        m_busy = 1; m_fc = '0;
        k = 0;
        while (frame_cnt_o != 5 && k < 3000) begin tick(); k++; end
        check("ab_fc_time", cyc, (done_q.size() >= 5) ? done_q[4] + 1 : -1);
        ab_c = cyc;
        host_write(0, 32'h4);
        wait_irq("ab", 100);
        repeat (3) tick();
        m_busy = 0; m_aborted = 1; m_fc = 16'd5;
        check("ab_soft_cycles", soft_n, 2);
        check("ab_soft_first", soft_first, ab_c + 1);
        check("ab_irq_count", irq_n, 1);
        check("ab_start_count", start_q.size(), 5);
        check("ab_busy", 32'(busy_o), 0);
        host_read("ab_status", 4'd6);
        check("ab_status_lit", host_rdata, 32'h0005_0004);

        // Write protection while busy
        run_check("prot", 2, 5, 30, 1'b1);
        drv_read("prot_integ", 4'd1);
        host_read("prot_gp9", 4'd9);
        host_read("prot_status", 4'd6);
        check("prot_wr_err", 32'(host_rdata[3]), 1);
        run_check("clr", 1, 0, 4, 1'b0);
        host_read("clr_status", 4'd6);

        // GO together with ABORT in IDLE: no run starts
        clear_mon();
        host_write(0, 32'h5);
        repeat (5) tick();
        check("goab_busy", 32'(busy_o), 0);
        check("goab_starts", start_q.size(), 0);

        // Watchdog
        host_write(5, 32'd20);
        resp_en = 1'b0;
        clear_mon();
        go_c = cyc;
        host_write(0, 32'h1);
        m_busy = 1; m_fc = '0;
`ifdef G11620_SCHED_TIMEOUT_EN
        wait_irq("wd", 200);
        repeat (3) tick();
        m_busy = 0; m_timeout = 1; m_aborted = 1;
        check("wd_soft_first", soft_first, go_c + 2 + 20);
        check("wd_soft_cycles", soft_n, 2);
        check("wd_busy", 32'(busy_o), 0);
        host_read("wd_status", 4'd6);
        resp_dly = 5; resp_en = 1'b1;
        host_write(0, 32'h3);
        m_busy = 1;
        repeat (40) tick();
`else
        repeat (100) tick();
        check("nowd_busy", 32'(busy_o), 1);
        check("nowd_soft", soft_n, 0);
        check("nowd_irq", irq_n, 0);
        check("nowd_starts", start_q.size(), 1);
        host_read("nowd_status", 4'd6);
`endif

        // Synchronous reset in the middle of a run
        rst_n = 1'b0;
        tick();
        check("mrst_busy", 32'(busy_o), 0);
        check("mrst_fc", 32'(frame_cnt_o), 0);
        check("mrst_soft", 32'(drv_soft_reset_o), 0);
        check("mrst_start", 32'(drv_start_o), 0);
        rst_n = 1'b1;
        resp_en = 1'b0;
        model_reset();
        tick();
        drv_read("mrst_integ", 4'd1);
        host_read("mrst_status", 4'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
